pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Program-counter stage directly downstream of sign_extend_shifter in the 16-bit CPU datapath.
- Holds the architectural PC and advances it sequentially by 2 each cycle.
- On a branch or jump, adds the shifted, sign-extended offset to the PC to form the target, and redirects fetch.
- Runs a small state machine that inserts a bubble after reset and after every redirect, and drives flush to the fetch/decode latches.

Parameters:
- WIDTH, 16, PC and offset width in bits.
- RESET_VECTOR, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- INC, 2, sequential PC increment in bytes (halfword instructions).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC; no advance this cycle.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- jump  in  1  unconditional jump this cycle.
- offset  in  WIDTH  sign-extended, left-shifted displacement from sign_extend_shifter.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus_inc  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- flush  out  1  squash the instruction in the fetch/decode latch (registered, 1-cycle pulse).
- align_err  out  1  sticky flag: a redirect was accepted with offset[0]=1.

Behaviour:
- Reset (asynchronous, any cycle, including mid-redirect):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, align_err=0.
- Redirect definition:
  - redirect = branch_taken | jump.
  - target = pc + INC + offset, truncated to WIDTH bits (wrap-around, no overflow flag).
- Priority, highest first: reset > redirect > stall > sequential increment.
- States (2-bit encoding):
  - BOOT: fetch_valid=0; inputs ignored. Next cycle goes to RUN; pc stays at RESET_VECTOR.
  - RUN: fetch_valid=1.
    - On redirect: pc<=target, flush<=1, state<=BUBBLE. The redirect is accepted even when stall=1.
    - Else if stall: pc holds, flush<=0.
    - Else: pc<=pc+INC, flush<=0.
  - BUBBLE: fetch_valid=0, flush<=0, redirect inputs ignored (the squashed slot cannot issue one).
    - If stall: stay in BUBBLE and hold pc.
    - Else: go to RUN; pc holds (the target is fetched in the first RUN cycle).
- Redirect latency: target appears on pc 1 cycle after the redirect cycle; fetch_valid returns 2 cycles after it (absent stall).
- Simultaneous branch_taken and jump: treated as a single redirect with the same target; no error.
- Wrap-around:
  - pc=16'hFFFE with no redirect -> next pc=16'h0000.
  - Target arithmetic wraps modulo 2^16.
- align_err: set on an accepted redirect with offset[0]=1 and cleared only by reset. The target is still loaded unmodified.
- Combinational paths:
  - pc_plus_inc depends only on pc.
  - No combinational path from inputs to outputs except pc_plus_inc.

Decomposition:
- Shared package/header: WIDTH default, INC, RESET_VECTOR, and state encodings ST_BOOT=2'd0, ST_RUN=2'd1, ST_BUBBLE=2'd2.
- One sub-module, pc_adder: a WIDTH-bit ripple adder producing pc+INC and the target sum. It is reused by the arithmetic directory; the FSM and registers stay in pc_branch_unit.

Test Plan:
- Reset then release, stall=0 -> cycle 0: pc=0000, fetch_valid=0; then fetch_valid=1 with pc=0000, 0002, 0004 on successive cycles.
- At pc=0010, branch_taken=1, offset=16'h0020 -> next cycle pc=0032, flush=1, fetch_valid=0; following cycle pc=0032, fetch_valid=1; then pc=0034.
- At pc=0040, jump=1, offset=16'hFFF0 (-16) -> pc=0032, flush pulse of exactly 1 cycle, align_err=0.
- Run up to pc=FFFE with no redirects -> next pc=0000; then pc=FFFC with offset=0004 branch -> target=0002 (wraps).
- stall=1 for 3 cycles at pc=0008 -> pc holds 0008. A jump with offset=0010 during the stall -> pc=001A. Redirect inputs asserted in BUBBLE are ignored.
- Branch with offset=16'h0003 -> align_err=1 and stays set. Assert reset mid-BUBBLE -> pc=0000, align_err=0, flush=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared constants and FSM state encoding for the program-counter stage.
package pc_branch_unit_pkg;

  localparam int          DEF_WIDTH        = 16;
  localparam int          DEF_INC          = 2;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

endpackage

// File: rtl/pc_adder.sv
// WIDTH-bit ripple-carry adder; carry out is dropped so sums wrap modulo 2^WIDTH.
module pc_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump redirect and a one-slot bubble after reset
// and after every redirect; flush squashes the fetch/decode latch.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               INC          = DEF_INC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             align_err
);

  state_t           state;
  logic             redirect;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] target;

  assign inc_val  = WIDTH'(INC);
  assign redirect = branch_taken | jump;

  // Target is formed from pc+INC so both sums share the first adder.
  pc_adder #(.WIDTH(WIDTH)) u_inc_adder (
    .a   (pc),
    .b   (inc_val),
    .sum (pc_plus_inc)
  );

  pc_adder #(.WIDTH(WIDTH)) u_target_adder (
    .a   (pc_plus_inc),
    .b   (offset),
    .sum (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
        end
        ST_RUN: begin
          // A redirect wins over stall: the resolving instruction must not be lost.
          if (redirect) begin
            pc          <= target;
            flush       <= 1'b1;
            fetch_valid <= 1'b0;
            state       <= ST_BUBBLE;
            if (offset[0]) align_err <= 1'b1;
          end else begin
            flush <= 1'b0;
            if (!stall) pc <= pc_plus_inc;
          end
        end
        ST_BUBBLE: begin
          // The squashed slot cannot redirect; pc holds so the target is fetched next.
          flush <= 1'b0;
          if (!stall) begin
            state       <= ST_RUN;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          state       <= ST_BOOT;
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed scoreboard bench for pc_branch_unit.
module tb_pc_branch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [15:0] offset;
  logic [15:0] pc;
  logic [15:0] pc_plus_inc;
  logic        fetch_valid;
  logic        flush;
  logic        align_err;

  pc_branch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .offset       (offset),
    .pc           (pc),
    .pc_plus_inc  (pc_plus_inc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic        fv;
    logic        fl;
    logic        ae;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: 0=BOOT 1=RUN 2=BUBBLE
  int          m_st;
  logic [15:0] m_pc;
  logic        m_fv, m_fl, m_ae;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 16'h0000; m_fv = 1'b0; m_fl = 1'b0; m_ae = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic s, input logic b, input logic j,
                      input logic [15:0] o, input string tag);
    exp_t e;
    stall = s; branch_taken = b; jump = j; offset = o;
    case (m_st)
      0: begin m_st = 1; m_fv = 1'b1; m_fl = 1'b0; end
      1: begin
        if (b || j) begin
          m_pc = m_pc + 16'd2 + o;
          m_fl = 1'b1; m_fv = 1'b0; m_st = 2;
          if (o[0]) m_ae = 1'b1;
        end else begin
          m_fl = 1'b0;
          if (!s) m_pc = m_pc + 16'd2;
        end
      end
      default: begin
        m_fl = 1'b0;
        if (!s) begin m_st = 1; m_fv = 1'b1; end
      end
    endcase
    e.pc = m_pc; e.fv = m_fv; e.fl = m_fl; e.ae = m_ae;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected 1 entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_fv"}, 16'(fetch_valid), 16'(e.fv));
      chk({tag, "_flush"}, 16'(flush), 16'(e.fl));
      chk({tag, "_aerr"}, 16'(align_err), 16'(e.ae));
      chk({tag, "_inc"}, pc_plus_inc, pc + 16'd2);
    end
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; offset = 16'h0000;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, tag);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_fv"}, 16'(fetch_valid), 16'h0000);
    chk({tag, "_flush"}, 16'(flush), 16'h0000);
    chk({tag, "_aerr"}, 16'(align_err), 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [15:0] off;

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; offset = 16'h0000;
    #2;
    apply_reset("reset0");
    chk("boot_pc", pc, 16'h0000);
    chk("boot_fv", 16'(fetch_valid), 16'h0000);

    // Boot bubble then sequential fetch
    step(1'b0, 1'b0, 1'b0, 16'h0000, "seq0");
    chk("seq_pc0", pc, 16'h0000);
    chk("seq_fv0", 16'(fetch_valid), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "seq1");
    chk("seq_pc2", pc, 16'h0002);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "seq2");
    chk("seq_pc4", pc, 16'h0004);
    run(6, "seq");
    chk("at_0010", pc, 16'h0010);

    // Forward branch
    step(1'b0, 1'b1, 1'b0, 16'h0020, "br");
    chk("br_pc", pc, 16'h0032);
    chk("br_flush", 16'(flush), 16'h0001);
    chk("br_fv", 16'(fetch_valid), 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "br_b");
    chk("br_tgt_fetch", pc, 16'h0032);
    chk("br_fv_back", 16'(fetch_valid), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "br_n");
    chk("br_next", pc, 16'h0034);
    run(6, "seq3");
    chk("at_0040", pc, 16'h0040);

    // Backward jump
    step(1'b0, 1'b0, 1'b1, 16'hFFF0, "jmp");
    chk("jmp_pc", pc, 16'h0032);
    chk("jmp_flush", 16'(flush), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "jmp_b");
    chk("jmp_flush_1cyc", 16'(flush), 16'h0000);
    chk("jmp_aerr", 16'(align_err), 16'h0000);

    // Stall, jump during stall, redirects ignored in BUBBLE
    apply_reset("reset1");
    run(5, "to8");
    chk("at_0008", pc, 16'h0008);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, "stall");
    chk("stall_hold", pc, 16'h0008);
    step(1'b1, 1'b0, 1'b1, 16'h0010, "stall_jmp");
    chk("stall_jmp_pc", pc, 16'h001A);
    step(1'b1, 1'b1, 1'b0, 16'h0100, "bub_stall_br");
    chk("bub_ign0", pc, 16'h001A);
    step(1'b0, 1'b0, 1'b1, 16'h0100, "bub_jmp");
    chk("bub_ign1", pc, 16'h001A);
    chk("bub_exit_fv", 16'(fetch_valid), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "post_bub");
    chk("post_bub_pc", pc, 16'h001C);

    // Branch and jump together
    step(1'b0, 1'b1, 1'b1, 16'h0004, "both");
    chk("both_pc", pc, 16'h0022);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "both_b");

    // Sequential wrap at FFFE
    off = 16'hFFF8 - pc - 16'd2;
    step(1'b0, 1'b0, 1'b1, off, "to_fff8");
    chk("at_fff8", pc, 16'hFFF8);
    run(4, "wrap");
    chk("at_fffe", pc, 16'hFFFE);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "wrap0");
    chk("wrap_0000", pc, 16'h0000);

    // Target arithmetic wrap
    off = 16'hFFFC - pc - 16'd2;
    step(1'b0, 1'b0, 1'b1, off, "to_fffc");
    step(1'b0, 1'b0, 1'b0, 16'h0000, "fffc_b");
    chk("at_fffc", pc, 16'hFFFC);
    step(1'b0, 1'b1, 1'b0, 16'h0004, "br_wrap");
    chk("br_wrap_pc", pc, 16'h0002);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "br_wrap_b");

    // Misaligned redirect: sticky align_err, target unmodified
    step(1'b0, 1'b1, 1'b0, 16'h0003, "mis");
    chk("mis_pc", pc, 16'h0007);
    chk("mis_aerr", 16'(align_err), 16'h0001);
    run(3, "mis_hold");
    chk("mis_sticky", 16'(align_err), 16'h0001);

    // Asynchronous reset in the middle of a BUBBLE
    step(1'b0, 1'b1, 1'b0, 16'h0003, "mis2");
    chk("mis2_flush", 16'(flush), 16'h0001);
    #2;
    apply_reset("reset_async");
    step(1'b0, 1'b0, 1'b0, 16'h0000, "after_rst");
    chk("after_rst_pc", pc, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "after_rst1");
    chk("after_rst_pc2", pc, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
